dot_glyph_loader: RTL

Upstream feeder for the 5x7 dot-matrix column-scan controller. Accepts a 4-bit hex character code over a valid/ready handshake and looks it up in an internal 16-entry 5x7 font ROM. Writes the five glyph columns into the controller's column memory through its col_addr/row_data/write interface. Also generates the controller's scan-enable strobe, so each column write is sequenced against the strobe that the controller samples.

---
 rtl/dot_glyph_loader_if.sv | 31 +++
 rtl/dot_glyph_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dot_glyph_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_glyph_loader_if
// Description : Character request handshake plus column-memory write bus
//               between the glyph loader and the 5x7 column-scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_glyph_loader_if;
  logic [3:0] char_code;
  logic       char_blank;
  logic       char_valid;
  logic       char_ready;
  logic       scan_en;
  logic [4:0] col_addr;
  logic [6:0] row_data;
  logic       write;
  logic       load_done;

  // Loader side: consumes character requests, drives the controller bus
  modport master (
    input  char_code, char_blank, char_valid,
    output char_ready, scan_en, col_addr, row_data, write, load_done
  );

  // Requester / controller side
  modport slave (
    output char_code, char_blank, char_valid,
    input  char_ready, scan_en, col_addr, row_data, write, load_done
  );
endinterface
`default_nettype wire

// File: rtl/dot_glyph_loader.sv
`default_nettype none
// ============================================================================
// Module      : dot_glyph_loader
// Description : Looks up a hex digit in a 5x7 font ROM and writes its five
//               columns to the scan controller, paced by its own scan strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_glyph_loader #(
  parameter int SCAN_DIV = 4,
  parameter int INVERT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  dot_glyph_loader_if.master bus
);

  localparam logic [15:0] c_LAST_CNT = 16'(SCAN_DIV - 1);
  localparam logic [4:0]  c_LAST_COL = 5'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_preCnt;
  logic        r_scanEn;
  logic [3:0]  r_code;
  logic        r_blank;
  logic [4:0]  r_colAddr;
  logic [6:0]  r_rowData;
  logic        r_write;
  logic        r_loadDone;
  logic [4:0]  w_nextCol;

  // Five 7-bit columns packed left (column 0) to right (column 4)
  function automatic logic [34:0] fontWord(input logic [3:0] code);
    logic [34:0] w;
    case (code)
      4'h0: w = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
      4'h1: w = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
      4'h2: w = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
      4'h3: w = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
      4'h4: w = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
      4'h5: w = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
      4'h6: w = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
      4'h7: w = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
      4'h8: w = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      4'h9: w = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
      4'hA: w = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
      4'hB: w = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
      4'hC: w = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
      4'hD: w = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
      4'hE: w = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
      default: w = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
    endcase
    return w;
  endfunction

  // Blanking is applied before the optional inversion
  function automatic logic [6:0] glyphCol(input logic [3:0] code, input logic blank,
                                          input logic [4:0] col);
    logic [34:0] w;
    logic [6:0]  c;
    w = fontWord(code);
    case (col)
      5'd0:    c = w[34:28];
      5'd1:    c = w[27:21];
      5'd2:    c = w[20:14];
      5'd3:    c = w[13:7];
      default: c = w[6:0];
    endcase
    if (blank) c = 7'h00;
    return (INVERT != 0) ? ~c : c;
  endfunction

  assign w_nextCol = r_colAddr + 5'd1;

  // Free-running prescaler, independent of the load state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_preCnt <= '0;
      r_scanEn <= 1'b0;
    end else begin
      r_preCnt <= (r_preCnt == c_LAST_CNT) ? 16'd0 : r_preCnt + 16'd1;
      r_scanEn <= (r_preCnt == c_LAST_CNT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_code     <= '0;
      r_blank    <= 1'b0;
      r_colAddr  <= '0;
      r_rowData  <= '0;
      r_write    <= 1'b0;
      r_loadDone <= 1'b0;
    end else begin
      r_loadDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.char_valid) begin
            r_state   <= ST_WRITE;
            r_code    <= bus.char_code;
            r_blank   <= bus.char_blank;
            r_colAddr <= 5'd0;
            r_rowData <= glyphCol(bus.char_code, bus.char_blank, 5'd0);
            r_write   <= 1'b1;
          end
        end
        ST_WRITE: begin
          // The controller only takes a column while its enable is high
          if (r_scanEn) begin
            if (r_colAddr == c_LAST_COL) begin
              r_state    <= ST_IDLE;
              r_write    <= 1'b0;
              r_loadDone <= 1'b1;
            end else begin
              r_colAddr <= w_nextCol;
              r_rowData <= glyphCol(r_code, r_blank, w_nextCol);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.char_ready = (r_state == ST_IDLE);
  assign bus.scan_en    = r_scanEn;
  assign bus.col_addr   = r_colAddr;
  assign bus.row_data   = r_rowData;
  assign bus.write      = r_write;
  assign bus.load_done  = r_loadDone;

endmodule
`default_nettype wire
